fifo_word_packer: RTL and testbench

- Sits directly downstream of the team's ring_fifo / shift_fifo byte buffers; interchangeable with either, since both share one interface.
- Pops DATA_W-bit entries from the FIFO head and packs LANES consecutive entries into one wide word.
- Presents the word on a valid/ready output port, with a per-lane keep mask.
- A flush request emits a partially filled word, so the tail of a burst is never stranded.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_word_packer_lane_accumulator.sv | 70 +++++++
 rtl/fifo_word_packer.sv | 100 ++++++++++
 tb/tb_fifo_word_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO word packer:
//   - default entry width and lane count
//   - packer state encoding (FILL accumulating, HOLD word presented)
//   - thermometer keep-mask builder
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LANES_DEF  = 4;
  localparam int LANES_MAX  = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_e;

  // Lanes 0..n-1 set, everything above cleared.
  function automatic logic [LANES_MAX-1:0] therm_mask(input int unsigned n);
    logic [LANES_MAX-1:0] m;
    for (int i = 0; i < LANES_MAX; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_word_packer_lane_accumulator.sv
// ---------------------------------------------------------------------------
// lane_accumulator
// Holds the wide data word, its keep mask and the lane count for the packer.
// Ports:
//   clk, reset  : clock, synchronous active-low reset (clears everything)
//   clr_i       : discard the current word (cnt, data and keep go to zero)
//   wr_i        : write wdata_i into lane cnt and advance cnt; when combined
//                 with clr_i the write lands in lane 0 of a fresh word
//   wdata_i     : entry to write
//   data_o      : packed word, lane 0 in the LSBs, unused lanes zero
//   keep_o      : thermometer mask of filled lanes
//   cnt_o       : number of filled lanes (0..LANES)
// ---------------------------------------------------------------------------
module lane_accumulator
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int CNT_W  = $clog2(LANES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       wr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W*LANES-1:0]    data_o,
  output logic [LANES-1:0]           keep_o,
  output logic [CNT_W-1:0]           cnt_o
);

  logic [DATA_W*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]        keep_q, keep_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    // Clear first so a simultaneous write starts a new word at lane 0.
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end
    if (wr_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (CNT_W'(l) == cnt_d) begin
          data_d[l*DATA_W +: DATA_W] = wdata_i;
        end
      end
      cnt_d = cnt_d + CNT_W'(1);
    end
    keep_d = LANES'(therm_mask(32'(cnt_d)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      keep_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign keep_o = keep_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/fifo_word_packer.sv
// ---------------------------------------------------------------------------
// fifo_word_packer
// Pops DATA_W-bit entries from a first-word-fall-through FIFO head and packs
// LANES consecutive entries into one wide word with a per-lane keep mask.
// A flush request emits a partially filled word.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   fifo_val    : FIFO head valid
//   fifo_data   : FIFO head entry
//   fifo_read   : pop request to the FIFO (combinational)
//   flush       : level request to emit the current partial word
//   word_valid  : packed word available (registered)
//   word_data   : packed word, lane 0 in the LSBs
//   word_keep   : bit i set when lane i holds real data
//   word_ready  : downstream accepts the word
//   busy        : any data held (partial word or presented word)
// ---------------------------------------------------------------------------
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_val,
  input  logic [DATA_W-1:0]          fifo_data,
  output logic                       fifo_read,
  input  logic                       flush,
  output logic                       word_valid,
  output logic [DATA_W*LANES-1:0]    word_data,
  output logic [LANES-1:0]           word_keep,
  input  logic                       word_ready,
  output logic                       busy
);

  localparam int CNT_W = $clog2(LANES + 1);

  pk_state_e        state_q, state_d;
  logic             word_valid_q;
  logic             acc_wr, acc_clr;
  logic [CNT_W-1:0] cnt;

  // In HOLD a pop is only allowed when the presented word leaves this cycle,
  // so an unaccepted word is never overwritten.
  assign fifo_read = reset & fifo_val &
                     ((state_q == FILL) | ((state_q == HOLD) & word_ready));

  assign acc_wr  = fifo_read;
  assign acc_clr = (state_q == HOLD) & word_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        // Last lane filled, or flush with something to emit (held or
        // arriving this cycle). Flush with nothing held is ignored.
        if ((fifo_read && (cnt == CNT_W'(LANES - 1))) ||
            (flush && ((cnt != '0) || fifo_read))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FILL;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_valid_q <= (state_d == HOLD);
    end
  end

  lane_accumulator #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (acc_clr),
    .wr_i    (acc_wr),
    .wdata_i (fifo_data),
    .data_o  (word_data),
    .keep_o  (word_keep),
    .cnt_o   (cnt)
  );

  assign word_valid = word_valid_q;
  assign busy       = (cnt != '0) | (state_q == HOLD);

endmodule

// File: tb/tb_fifo_word_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_word_packer
// Drives fifo_word_packer from a behavioural FIFO (queue, capacity 10, FWFT)
// and compares every cycle against a queue-level model of word formation.
// ---------------------------------------------------------------------------
module tb_fifo_word_packer;

  localparam int DATA_W    = 8;
  localparam int LANES     = 4;
  localparam int FIFO_SIZE = 10;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    fifo_val;
  logic [DATA_W-1:0]       fifo_data;
  logic                    fifo_read;
  logic                    flush;
  logic                    word_valid;
  logic [DATA_W*LANES-1:0] word_data;
  logic [LANES-1:0]        word_keep;
  logic                    word_ready;
  logic                    busy;

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;

  logic [7:0] fq[$];      // upstream FIFO contents, head at index 0
  bit         src_en;     // FIFO presents its head only when set
  logic [7:0] m_acc[$];   // model: bytes collected toward the next word
  logic [7:0] m_word[$];  // model: bytes of the presented word
  bit         m_hold;     // model: a word is being presented

  fifo_word_packer #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_val   (fifo_val),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .flush      (flush),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_keep  (word_keep),
    .word_ready (word_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input logic [7:0] b[$]);
    logic [31:0] w;
    w = '0;
    foreach (b[i]) w = w | (32'(b[i]) << (8 * i));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_val  = src_en && (fq.size() > 0);
    fifo_data = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [7:0] b);
    if (fq.size() < FIFO_SIZE) fq.push_back(b);
    refresh();
  endtask

  // One clock cycle: check the pop request before the edge, advance FIFO and
  // model at the edge, then check the registered outputs after it.
  task automatic tick();
    bit         exp_read;
    bit         obs_read;
    bit         was_hold;
    logic [7:0] head;
    @(negedge clk);
    exp_read = reset && fifo_val && (!m_hold || word_ready);
    obs_read = fifo_read;
    chk("fifo_read", 64'(fifo_read), 64'(exp_read));
    head = fifo_data;
    @(posedge clk);
    #1;
    if (obs_read && fq.size() > 0) begin
      void'(fq.pop_front());
      pop_cnt++;
    end
    if (!reset) begin
      m_hold = 1'b0;
      m_acc.delete();
      m_word.delete();
    end else begin
      was_hold = m_hold;
      if (m_hold && word_ready) begin
        m_hold = 1'b0;
        m_word.delete();
      end
      if (exp_read) m_acc.push_back(head);
      if (m_acc.size() == LANES || (!was_hold && flush && m_acc.size() > 0)) begin
        m_word = m_acc;
        m_acc.delete();
        m_hold = 1'b1;
      end
    end
    refresh();
    chk("word_valid", 64'(word_valid), 64'(m_hold));
    chk("busy", 64'(busy), 64'(m_hold || m_acc.size() > 0));
    if (m_hold) begin
      chk("word_data", 64'(word_data), 64'(pack(m_word)));
      chk("word_keep", 64'(word_keep), 64'((1 << m_word.size()) - 1));
    end
  endtask

  initial begin
    reset      = 1'b0;
    src_en     = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b0;
    m_hold     = 1'b0;
    refresh();

    // Reset held with a valid FIFO head: no pops, outputs cleared.
    push(8'h5A);
    src_en = 1'b1;
    refresh();
    repeat (3) begin
      tick();
      chk("rst_data", 64'(word_data), 64'h0);
      chk("rst_keep", 64'(word_keep), 64'h0);
      chk("rst_valid", 64'(word_valid), 64'h0);
    end
    fq.delete();
    refresh();
    reset = 1'b1;
    tick();

    // Full word.
    word_ready = 1'b1;
    pop_cnt    = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (4) tick();
    chk("full_valid", 64'(word_valid), 64'h1);
    chk("full_data", 64'(word_data), 64'h44332211);
    chk("full_keep", 64'(word_keep), 64'hF);
    tick();
    chk("full_valid_drop", 64'(word_valid), 64'h0);
    chk("full_pops", 64'(pop_cnt), 64'd4);

    // Partial flush.
    push(8'hA1); push(8'hB2);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pflush_data", 64'(word_data), 64'h0000B2A1);
    chk("pflush_keep", 64'(word_keep), 64'h3);
    tick();

    // Flush and pop in the same cycle.
    push(8'h01); push(8'h02);
    repeat (2) tick();
    push(8'h03);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fpop_data", 64'(word_data), 64'h00030201);
    chk("fpop_keep", 64'(word_keep), 64'h7);
    tick();

    // Back-pressure, then back-to-back words.
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    repeat (4) tick();
    repeat (5) begin
      tick();
      chk("bp_valid", 64'(word_valid), 64'h1);
      chk("bp_data", 64'(word_data), 64'h03020100);
    end
    word_ready = 1'b1;
    repeat (3) tick();
    chk("b2b_wait", 64'(word_valid), 64'h0);
    tick();
    chk("b2b_valid", 64'(word_valid), 64'h1);
    chk("b2b_data", 64'(word_data), 64'h07060504);
    tick();

    // Flush with nothing held emits nothing.
    flush = 1'b1;
    repeat (3) tick();
    chk("idle_flush_valid", 64'(word_valid), 64'h0);
    flush = 1'b0;

    // Reset in the middle of a word.
    push(8'hC1); push(8'hC2); push(8'hC3);
    repeat (3) tick();
    chk("pre_rst_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_keep", 64'(word_keep), 64'h0);
    reset = 1'b1;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    repeat (4) tick();
    chk("post_rst_data", 64'(word_data), 64'hD4D3D2D1);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1) push(8'($urandom));
      src_en     = ($urandom_range(0, 9) < 8);
      flush      = ($urandom_range(0, 9) == 0);
      word_ready = ($urandom_range(0, 9) < 6);
      refresh();
      tick();
    end

    // Drain whatever is left.
    src_en     = 1'b1;
    word_ready = 1'b1;
    flush      = 1'b1;
    refresh();
    repeat (20) tick();
    chk("drain_busy", 64'(busy), 64'h0);
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
